// File: rtl/usb_uart_pkg.sv
// Shared constants for the USB CDC / UART-style byte bridge.
package usb_uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/usb_uart_fifo_bridge_if.sv
// Application-side UART-style port plus the CDC endpoint byte streams.
// The master modport is whoever drives the requests (application and endpoint
// engine); the slave modport is the bridge itself.
interface usb_uart_fifo_bridge_if;
    import usb_uart_pkg::*;

    logic              uart_we;
    logic [BYTE_W-1:0] uart_di;
    logic              uart_re;
    logic [BYTE_W-1:0] uart_do;
    logic              uart_wait;

    logic [BYTE_W-1:0] ep_in_data;
    logic              ep_in_valid;
    logic              ep_in_ready;

    logic [BYTE_W-1:0] ep_out_data;
    logic              ep_out_valid;
    logic              ep_out_ready;

    modport master (
        output uart_we, uart_di, uart_re, ep_in_ready, ep_out_data, ep_out_valid,
        input  uart_do, uart_wait, ep_in_data, ep_in_valid, ep_out_ready
    );

    modport slave (
        input  uart_we, uart_di, uart_re, ep_in_ready, ep_out_data, ep_out_valid,
        output uart_do, uart_wait, ep_in_data, ep_in_valid, ep_out_ready
    );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO. Push and pop requests are gated
// internally by full/empty as seen at the start of the cycle, so a pop never
// frees space for a push in the same cycle and a push into an empty FIFO is
// only visible at the head one cycle later.
module byte_fifo
    import usb_uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              doPush, doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Pointers wrap naturally at DEPTH; count moves only when exactly one side fires.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + AW'(1);
        if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
        if (doPush && !doPop)      count_d = count_q + CW'(1);
        else if (doPop && !doPush) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers; reset discards whatever is stored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array needs no reset: empty pointers make old contents unreachable.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/usb_uart_fifo_bridge.sv
// Byte bridge between the application UART-style port and the USB CDC
// endpoint engine. TX carries application bytes towards the host (IN
// endpoint), RX carries host bytes towards the application (OUT endpoint).
module usb_uart_fifo_bridge
    import usb_uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk_48mhz,
    input  logic                   reset,
    usb_uart_fifo_bridge_if.slave  bus,
    output logic [CW-1:0]          tx_count,
    output logic [CW-1:0]          rx_count
);

    logic              txFull, txEmpty;
    logic              rxFull, rxEmpty;
    logic [BYTE_W-1:0] rxHead;
    logic [BYTE_W-1:0] uartDo_q, uartDo_d;

    byte_fifo #(.DEPTH(DEPTH), .CW(CW)) txFifo (
        .clk_i   (clk_48mhz),
        .rst_i   (reset),
        .push_i  (bus.uart_we),
        .data_i  (bus.uart_di),
        .pop_i   (bus.ep_in_ready),
        .data_o  (bus.ep_in_data),
        .full_o  (txFull),
        .empty_o (txEmpty),
        .count_o (tx_count)
    );

    byte_fifo #(.DEPTH(DEPTH), .CW(CW)) rxFifo (
        .clk_i   (clk_48mhz),
        .rst_i   (reset),
        .push_i  (bus.ep_out_valid),
        .data_i  (bus.ep_out_data),
        .pop_i   (bus.uart_re),
        .data_o  (rxHead),
        .full_o  (rxFull),
        .empty_o (rxEmpty),
        .count_o (rx_count)
    );

    assign bus.ep_in_valid  = !txEmpty;
    assign bus.ep_out_ready = !rxFull;
    assign bus.uart_wait    = (bus.uart_we && txFull) || (bus.uart_re && rxEmpty);
    assign bus.uart_do      = uartDo_q;

    // Capture the RX head on an accepted read; otherwise hold the last byte.
    always_comb begin
        uartDo_d = uartDo_q;
        if (bus.uart_re && !rxEmpty) uartDo_d = rxHead;
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) uartDo_q <= '0;
        else       uartDo_q <= uartDo_d;
    end

endmodule

// File: tb/tb_usb_uart_fifo_bridge.sv
// Directed bench for the USB/UART byte bridge: reset, write path, read
// latency, empty stall, full boundary and a randomised loopback.
module tb_usb_uart_fifo_bridge;

    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NLOOP = 200;

    logic          clk_48mhz = 1'b0;
    logic          reset     = 1'b1;
    logic [CW-1:0] tx_count, rx_count;

    int checks = 0;
    int errors = 0;

    usb_uart_fifo_bridge_if bus ();

    usb_uart_fifo_bridge #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .bus       (bus),
        .tx_count  (tx_count),
        .rx_count  (rx_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_48mhz = ~clk_48mhz;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] di, input logic re,
                                 input logic outValid, input logic [7:0] outData, input logic inReady);
        bus.uart_we      = we;
        bus.uart_di      = di;
        bus.uart_re      = re;
        bus.ep_out_valid = outValid;
        bus.ep_out_data  = outData;
        bus.ep_in_ready  = inReady;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk_48mhz);
        #1;
    endtask

    logic [7:0] hello [13];
    logic [7:0] src [NLOOP];

    // Directed test sequence.
    initial begin
        int sendIdx, recvIdx, appIdx, maxTx, maxRx, cyc;
        logic outAcc, inAcc, reAcc, weAcc;
        logic [7:0] expByte;

        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                  8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // 1. Reset, then reset again mid-stream with 5 bytes queued.
        stepCycle();
        stepCycle();
        checkOutput("por_tx_count", 32'(tx_count), 32'd0);
        checkOutput("por_ep_out_ready", 32'(bus.ep_out_ready), 32'd1);
        reset = 1'b0;
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
        stepCycle();
        bus.ep_out_data = 8'h22;
        stepCycle();
        bus.ep_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.uart_we = 1'b1;
            bus.uart_di = 8'hA1 + 8'(i);
            stepCycle();
        end
        bus.uart_we = 1'b0;
        bus.uart_re = 1'b1;
        stepCycle();
        bus.uart_re = 1'b0;
        checkOutput("pre_reset_uart_do", 32'(bus.uart_do), 32'h11);
        checkOutput("pre_reset_tx_count", 32'(tx_count), 32'd4);
        checkOutput("pre_reset_rx_count", 32'(rx_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_tx_count", 32'(tx_count), 32'd0);
        checkOutput("rst_rx_count", 32'(rx_count), 32'd0);
        checkOutput("rst_uart_do", 32'(bus.uart_do), 32'd0);
        checkOutput("rst_ep_in_valid", 32'(bus.ep_in_valid), 32'd0);
        checkOutput("rst_ep_out_ready", 32'(bus.ep_out_ready), 32'd1);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("rel_tx_count", 32'(tx_count), 32'd0);
        checkOutput("rel_rx_count", 32'(rx_count), 32'd0);
        checkOutput("rel_uart_do", 32'(bus.uart_do), 32'd0);
        checkOutput("rel_ep_in_valid", 32'(bus.ep_in_valid), 32'd0);
        checkOutput("rel_ep_out_ready", 32'(bus.ep_out_ready), 32'd1);

        // 2. Write path: "Hello World!\n" then drain in order.
        for (int i = 0; i < 13; i++) begin
            bus.uart_we = 1'b1;
            bus.uart_di = hello[i];
            #1;
            checkOutput("hello_wr_wait", 32'(bus.uart_wait), 32'd0);
            stepCycle();
        end
        bus.uart_we = 1'b0;
        checkOutput("hello_tx_count", 32'(tx_count), 32'd13);
        checkOutput("hello_head", 32'(bus.ep_in_data), 32'h48);
        bus.ep_in_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            checkOutput("hello_valid", 32'(bus.ep_in_valid), 32'd1);
            checkOutput("hello_byte", 32'(bus.ep_in_data), 32'(hello[i]));
            stepCycle();
        end
        bus.ep_in_ready = 1'b0;
        checkOutput("hello_drained_valid", 32'(bus.ep_in_valid), 32'd0);
        checkOutput("hello_drained_count", 32'(tx_count), 32'd0);

        // 3. Read latency.
        bus.ep_out_valid = 1'b1;
        bus.ep_out_data  = 8'h41;
        stepCycle();
        bus.ep_out_valid = 1'b0;
        checkOutput("rd_rx_count_1", 32'(rx_count), 32'd1);
        bus.uart_re = 1'b1;
        #1;
        checkOutput("rd_wait", 32'(bus.uart_wait), 32'd0);
        stepCycle();
        bus.uart_re = 1'b0;
        checkOutput("rd_uart_do", 32'(bus.uart_do), 32'h41);
        checkOutput("rd_rx_count_0", 32'(rx_count), 32'd0);

        // 4. Empty stall, released by a host push.
        bus.uart_re = 1'b1;
        #1;
        checkOutput("stall_wait", 32'(bus.uart_wait), 32'd1);
        stepCycle();
        checkOutput("stall_uart_do_held", 32'(bus.uart_do), 32'h41);
        checkOutput("stall_wait_held", 32'(bus.uart_wait), 32'd1);
        bus.ep_out_valid = 1'b1;
        bus.ep_out_data  = 8'h5A;
        #1;
        checkOutput("stall_wait_push_cycle", 32'(bus.uart_wait), 32'd1);
        stepCycle();
        bus.ep_out_valid = 1'b0;
        #1;
        checkOutput("stall_wait_dropped", 32'(bus.uart_wait), 32'd0);
        stepCycle();
        bus.uart_re = 1'b0;
        checkOutput("stall_uart_do", 32'(bus.uart_do), 32'h5A);
        checkOutput("stall_rx_count", 32'(rx_count), 32'd0);

        // 5. Full boundary on TX.
        bus.uart_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.uart_di = 8'(i);
            stepCycle();
        end
        bus.uart_di = 8'hEE;
        #1;
        checkOutput("full_tx_count", 32'(tx_count), 32'd64);
        checkOutput("full_wait", 32'(bus.uart_wait), 32'd1);
        stepCycle();
        checkOutput("full_count_held", 32'(tx_count), 32'd64);
        checkOutput("full_head", 32'(bus.ep_in_data), 32'h00);
        bus.ep_in_ready = 1'b1;
        #1;
        checkOutput("full_pop_cycle_wait", 32'(bus.uart_wait), 32'd1);
        stepCycle();
        bus.ep_in_ready = 1'b0;
        checkOutput("full_after_pop_count", 32'(tx_count), 32'd63);
        #1;
        checkOutput("full_after_pop_wait", 32'(bus.uart_wait), 32'd0);
        stepCycle();
        bus.uart_we = 1'b0;
        checkOutput("full_65th_count", 32'(tx_count), 32'd64);
        checkOutput("full_65th_head", 32'(bus.ep_in_data), 32'h01);
        bus.ep_in_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            expByte = (i < DEPTH - 1) ? 8'(i + 1) : 8'hEE;
            checkOutput("full_drain_byte", 32'(bus.ep_in_data), 32'(expByte));
            stepCycle();
        end
        bus.ep_in_ready = 1'b0;
        checkOutput("full_drained", 32'(tx_count), 32'd0);

        // 6. Loopback host -> RX -> application -> TX -> host with random gaps.
        for (int i = 0; i < NLOOP; i++) src[i] = 8'($urandom_range(255, 0));
        sendIdx = 0; recvIdx = 0; appIdx = 0; maxTx = 0; maxRx = 0;
        for (cyc = 0; cyc < 20000 && recvIdx < NLOOP; cyc++) begin
            if (sendIdx < NLOOP && $urandom_range(3, 0) != 0) begin
                bus.ep_out_valid = 1'b1;
                bus.ep_out_data  = src[sendIdx];
            end else begin
                bus.ep_out_valid = 1'b0;
            end
            bus.ep_in_ready = ($urandom_range(2, 0) != 0);
            if (!bus.uart_re && !bus.uart_we && $urandom_range(1, 0) == 1) bus.uart_re = 1'b1;
            #1;
            outAcc = bus.ep_out_valid && bus.ep_out_ready;
            inAcc  = bus.ep_in_valid && bus.ep_in_ready;
            reAcc  = bus.uart_re && !bus.uart_wait;
            weAcc  = bus.uart_we && !bus.uart_wait;
            if (inAcc) checkOutput("loop_out_byte", 32'(bus.ep_in_data), 32'(src[recvIdx]));
            if (int'(tx_count) > maxTx) maxTx = int'(tx_count);
            if (int'(rx_count) > maxRx) maxRx = int'(rx_count);
            stepCycle();
            if (outAcc) sendIdx++;
            if (inAcc)  recvIdx++;
            if (weAcc)  bus.uart_we = 1'b0;
            if (reAcc) begin
                checkOutput("loop_app_byte", 32'(bus.uart_do), 32'(src[appIdx]));
                appIdx++;
                bus.uart_re = 1'b0;
                bus.uart_we = 1'b1;
                bus.uart_di = bus.uart_do;
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("loop_received", 32'(recvIdx), 32'(NLOOP));
        checkOutput("loop_tx_le_depth", 32'(maxTx <= DEPTH), 32'd1);
        checkOutput("loop_rx_le_depth", 32'(maxRx <= DEPTH), 32'd1);
        stepCycle();
        checkOutput("loop_tx_empty", 32'(tx_count), 32'd0);
        checkOutput("loop_rx_empty", 32'(rx_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
